pktout_emit: RTL
================

Name: pktout_emit

Overview:
- Transmit-side counterpart of the ingress packet-state tracker in the output port lookup pipeline.
- Pops one per-packet forwarding decision (destination port bitmap plus drop flag) from the decision FIFO and pairs it with the buffered packet words.
- Forwarded packets go to the master AXI4-Stream with the decision stamped into the TUSER destination-port field; dropped packets are drained silently.
- Has a single registered output stage.

Parameters:
C_S_AXIS_TDATA_WIDTH, 256, data width of the slave and master streams.
C_S_AXIS_TUSER_WIDTH, 128, TUSER width of the slave and master streams.
DST_PORT_OFF, 24, bit offset of the 8-bit destination-port field in TUSER.

Ports:
clk  in  1  clock; all logic is rising-edge.
resetn  in  1  reset, synchronous and active-low.
s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  packet data.
s_axis_tstrb  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; valid on the first word.
s_axis_tvalid  in  1  slave word valid.
s_axis_tlast  in  1  last word of packet.
s_axis_tready  out  1  slave word accepted when high together with tvalid.
i_dec_valid  in  1  decision FIFO not empty.
i_dec_dst_port  in  8  one-hot or multicast destination bitmap.
i_dec_drop  in  1  drop packet.
o_dec_rd  out  1  one-cycle pop strobe to the decision FIFO.
m_axis_tdata  out  C_S_AXIS_TDATA_WIDTH  registered data.
m_axis_tstrb  out  C_S_AXIS_TDATA_WIDTH/8  registered strobes.
m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  registered sideband.
m_axis_tvalid  out  1  master word valid.
m_axis_tlast  out  1  master last word.
m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset: resetn low at a clock edge forces:
  - state = ST_IDLE;
  - m_axis_tvalid, m_axis_tlast, o_dec_rd = 0;
  - m_axis_tdata/tstrb/tuser = 0;
  - s_axis_tready = 0.
  - A packet in flight is abandoned; the upstream buffers are reset by the same resetn.
- Output stage: one register slot.
  - out_free = !m_axis_tvalid | m_axis_tready.
  - The slot loads on a forwarding accept. Otherwise m_axis_tvalid clears when m_axis_tready is high.
  - Latency is one cycle from slave accept to m_axis_tvalid.
  - m_axis_* are held stable while m_axis_tvalid & !m_axis_tready.
- States (localparams, nonzero): ST_IDLE=1, ST_FWD=2, ST_DROP=4.
- Effective drop: eff_drop = i_dec_drop | (i_dec_dst_port == 0).
- ST_IDLE:
  - s_axis_tready = i_dec_valid & (eff_drop | out_free).
  - On a first-word accept:
    - o_dec_rd = 1 in the same cycle (combinational, exactly one per packet).
    - If eff_drop: word is discarded; next state is ST_DROP, or ST_IDLE if tlast.
    - Else: word is loaded with TUSER[DST_PORT_OFF+7:DST_PORT_OFF] replaced by i_dec_dst_port, all other TUSER bits passed unchanged; next state is ST_FWD, or ST_IDLE if tlast.
  - No decision available: s_axis_tready = 0. The data stream stalls and nothing is popped.
- ST_FWD:
  - s_axis_tready = out_free.
  - Words pass through with TUSER unchanged.
  - Accepted tlast returns to ST_IDLE.
- ST_DROP:
  - s_axis_tready = 1; words are discarded.
  - Accepted tlast returns to ST_IDLE.
  - The output register keeps draining independently.
- Back-to-back packets: the first word of packet N+1 may be accepted in the cycle after the tlast of packet N. No bubble is required beyond the decision FIFO's availability.
- Single-word packet (first word with tlast): stays in ST_IDLE and pops exactly one decision.
- o_dec_rd is never asserted while i_dec_valid = 0.

Optional Feature:
- Macro PKTOUT_EMIT_STATS_EN.
- Defined:
  - Adds outputs o_pkts_sent[31:0] and o_pkts_dropped[31:0].
  - o_pkts_sent increments on each accepted forwarded tlast.
  - o_pkts_dropped increments on each eff_drop decision pop.
  - Both counters reset to 0, wrap modulo 2^32, and are registered.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include pktout_defs: state encodings, DST_PORT_OFF, SRC_PORT_OFF=16, decision record width (9 bits: drop + 8-bit port).
- One natural sub-module, axis_out_reg: the one-slot registered output stage (load/hold/clear, out_free).
- The FSM stays in pktout_emit.

Test Plan:
1. Reset behaviour: resetn low 3 cycles mid-packet -> m_axis_tvalid=0, o_dec_rd=0, s_axis_tready=0. Next packet after release emits correctly.
2. Single forward: decision port=0x04, 3-word packet with TUSER[31:24]=0x00, m_axis_tready=1:
   - o_dec_rd high 1 cycle with word 0;
   - m_axis_tuser[31:24]=0x04 on word 0 only;
   - tlast on the third output word, one cycle after the slave tlast.
3. Drop: decisions drop=1 and port=0x00 (separately), 4-word packets -> no m_axis_tvalid, s_axis_tready=1 throughout, one pop each. With stats enabled: o_pkts_dropped=2.
4. Backpressure: m_axis_tready toggles 1010…, 5-word packet -> no word lost or duplicated, outputs stable while stalled.
5. Decision starvation: data valid, i_dec_valid=0 for 10 cycles -> s_axis_tready=0, no pop. Decision arrives -> packet flows.
6. Back-to-back 1-word packets, decisions 0x01/0x02/0x08 -> three outputs with those ports on consecutive cycles, three pops.

Source files
------------

// File: rtl/pktout_emit_pkg.sv
// rtl/pktout_emit_pkg.sv - shared state encodings, TUSER field offsets and decision helpers for pktout_emit
package pktout_defs;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_FWD  = 3'b010,
      ST_DROP = 3'b100
   } state_t;

   localparam int DEF_DST_PORT_OFF = 24;
   localparam int DEF_SRC_PORT_OFF = 16;
   localparam int DEC_W            = 9;

   // A decision with an empty port bitmap has nowhere to go, so it is treated as a drop.
   function automatic logic is_eff_drop(input logic drop, input logic [7:0] port);
      return drop | (port == 8'h00);
   endfunction

endpackage

// File: rtl/pktout_emit_axis_out_reg.sv
// rtl/pktout_emit_axis_out_reg.sv - one-slot registered AXI4-Stream output stage (load/hold/clear)
module axis_out_reg #(
   parameter int DATA_W = 256,
   parameter int USER_W = 128
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                load_i,
   input  logic [DATA_W-1:0]   tdata_i,
   input  logic [DATA_W/8-1:0] tstrb_i,
   input  logic [USER_W-1:0]   tuser_i,
   input  logic                tlast_i,
   input  logic                tready_i,
   output logic                out_free_o,
   output logic [DATA_W-1:0]   tdata_o,
   output logic [DATA_W/8-1:0] tstrb_o,
   output logic [USER_W-1:0]   tuser_o,
   output logic                tvalid_o,
   output logic                tlast_o
);

   logic [DATA_W-1:0]   tdata_q;
   logic [DATA_W/8-1:0] tstrb_q;
   logic [USER_W-1:0]   tuser_q;
   logic                tvalid_q;
   logic                tlast_q;

   assign out_free_o = !tvalid_q | tready_i;

   // Payload is held whenever no new word loads, so a stalled word stays stable.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tdata_q  <= '0;
         tstrb_q  <= '0;
         tuser_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (load_i) begin
         tdata_q  <= tdata_i;
         tstrb_q  <= tstrb_i;
         tuser_q  <= tuser_i;
         tvalid_q <= 1'b1;
         tlast_q  <= tlast_i;
      end else if (tready_i) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end
   end

   assign tdata_o  = tdata_q;
   assign tstrb_o  = tstrb_q;
   assign tuser_o  = tuser_q;
   assign tvalid_o = tvalid_q;
   assign tlast_o  = tlast_q;

endmodule

// File: rtl/pktout_emit.sv
// rtl/pktout_emit.sv - pairs forwarding decisions with buffered packets and emits or drains them
// Optional packet counters under PKTOUT_EMIT_STATS_EN.
module pktout_emit
   import pktout_defs::*;
#(
   parameter int C_S_AXIS_TDATA_WIDTH = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int DST_PORT_OFF         = DEF_DST_PORT_OFF
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   input  logic                              i_dec_valid,
   input  logic [7:0]                        i_dec_dst_port,
   input  logic                              i_dec_drop,
   output logic                              o_dec_rd,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
`ifdef PKTOUT_EMIT_STATS_EN
   output logic [31:0]                       o_pkts_sent,
   output logic [31:0]                       o_pkts_dropped,
`endif
   input  logic                              m_axis_tready
);

   state_t                            state_q;
   logic                              out_free;
   logic                              eff_drop;
   logic                              s_ready;
   logic                              s_fire;
   logic                              first_pop;
   logic                              load;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   user_in;

   assign eff_drop = is_eff_drop(i_dec_drop, i_dec_dst_port);

   // Held low through reset so nothing upstream is consumed while the pipeline restarts.
   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         ST_IDLE: s_ready = i_dec_valid & (eff_drop | out_free);
         ST_FWD:  s_ready = out_free;
         ST_DROP: s_ready = 1'b1;
         default: s_ready = 1'b0;
      endcase
      if (!resetn) s_ready = 1'b0;
   end

   assign s_axis_tready = s_ready;
   assign s_fire        = s_axis_tvalid & s_ready;
   assign first_pop     = s_fire & (state_q == ST_IDLE);
   assign o_dec_rd      = first_pop;
   assign load          = s_fire & (((state_q == ST_IDLE) & !eff_drop) | (state_q == ST_FWD));

   always_comb begin
      user_in = s_axis_tuser;
      if (state_q == ST_IDLE) user_in[DST_PORT_OFF +: 8] = i_dec_dst_port;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (first_pop && !s_axis_tlast) state_q <= eff_drop ? ST_DROP : ST_FWD;
            end
            ST_FWD, ST_DROP: begin
               if (s_fire && s_axis_tlast) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   axis_out_reg #(
      .DATA_W (C_S_AXIS_TDATA_WIDTH),
      .USER_W (C_S_AXIS_TUSER_WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .resetn     (resetn),
      .load_i     (load),
      .tdata_i    (s_axis_tdata),
      .tstrb_i    (s_axis_tstrb),
      .tuser_i    (user_in),
      .tlast_i    (s_axis_tlast),
      .tready_i   (m_axis_tready),
      .out_free_o (out_free),
      .tdata_o    (m_axis_tdata),
      .tstrb_o    (m_axis_tstrb),
      .tuser_o    (m_axis_tuser),
      .tvalid_o   (m_axis_tvalid),
      .tlast_o    (m_axis_tlast)
   );

`ifdef PKTOUT_EMIT_STATS_EN
   logic [31:0] pkts_sent_q;
   logic [31:0] pkts_dropped_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pkts_sent_q    <= '0;
         pkts_dropped_q <= '0;
      end else begin
         if (load && s_axis_tlast)  pkts_sent_q    <= pkts_sent_q + 32'd1;
         if (first_pop && eff_drop) pkts_dropped_q <= pkts_dropped_q + 32'd1;
      end
   end

   assign o_pkts_sent    = pkts_sent_q;
   assign o_pkts_dropped = pkts_dropped_q;
`endif

endmodule
